// File: rtl/star_pkg.sv
// Shared types and defaults for the star-finding scan scheduler.
package star_pkg;

    localparam int unsigned X_RES_DEF     = 60;
    localparam int unsigned Y_RES_DEF     = 60;
    localparam int unsigned THRESHOLD_DEF = 0;
    localparam int unsigned XSZ_DEF       = 6;
    localparam int unsigned YSZ_DEF       = 6;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCheck,
        StLaunch,
        StWaitDone,
        StRecord,
        StDone
    } state_t;

    // One measured star: launch column, vertical extent and rightmost column.
    typedef struct packed {
        logic [XSZ_DEF-1:0] x;
        logic [YSZ_DEF-1:0] top;
        logic [YSZ_DEF-1:0] bottom;
        logic [XSZ_DEF-1:0] right;
    } star_rec_t;

endpackage

// File: rtl/star_table.sv
// Star table: MAX_STARS registered entries with valid bits, one write port,
// one combinational read port and parallel box-exclusion comparators.
module star_table
    import star_pkg::*;
#(
    parameter int unsigned MAX_STARS = 8
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         clear,
    input  logic                         we,
    input  logic [$clog2(MAX_STARS)-1:0] wr_idx,
    input  star_rec_t                    wr_data,
    input  logic [XSZ_DEF-1:0]           q_x,
    input  logic [YSZ_DEF-1:0]           q_y,
    output logic                         hit,
    input  logic [$clog2(MAX_STARS)-1:0] rd_idx,
    output star_rec_t                    rd_data
);

    star_rec_t              entries_q [MAX_STARS];
    logic [MAX_STARS-1:0]   valid_q;

    // Entry storage; clear invalidates every entry at the start of a scan.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            for (int i = 0; i < MAX_STARS; i++) begin
                entries_q[i] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
        end else if (we) begin
            entries_q[wr_idx] <= wr_data;
            valid_q[wr_idx]   <= 1'b1;
        end
    end

    // Query pixel is covered when it falls inside any valid entry's box.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < MAX_STARS; i++) begin
            if (valid_q[i] &&
                (q_x >= entries_q[i].x)   && (q_x <= entries_q[i].right) &&
                (q_y >= entries_q[i].top) && (q_y <= entries_q[i].bottom)) begin
                hit = 1'b1;
            end
        end
    end

    assign rd_data = entries_q[rd_idx];

endmodule

// File: rtl/star_scan_scheduler.sv
// Raster-scan sequencer: walks the image ROM, launches the measurement engine
// on uncovered bright pixels and records each star's box in star_table.
// Optional feature: define STAR_SCAN_TIMEOUT_EN to add a WAIT_DONE watchdog
// with a sticky meas_timeout output.
module star_scan_scheduler
    import star_pkg::*;
#(
    parameter int unsigned X_RES     = X_RES_DEF,
    parameter int unsigned Y_RES     = Y_RES_DEF,
    // XSZ/YSZ must match the star_rec_t field widths in star_pkg.
    parameter int unsigned XSZ       = XSZ_DEF,
    parameter int unsigned YSZ       = YSZ_DEF,
    parameter int unsigned ADDR_SZ   = 12,
    parameter int unsigned COL_SZ    = 3,
    parameter int unsigned THRESHOLD = THRESHOLD_DEF,
    parameter int unsigned MAX_STARS = 8
`ifdef STAR_SCAN_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 4095
`endif
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           start,
    output logic [ADDR_SZ-1:0]             pix_addr,
    input  logic [COL_SZ-1:0]              pix_val,
    output logic                           star_found,
    output logic [XSZ-1:0]                 star_x,
    output logic [YSZ-1:0]                 star_y,
    input  logic                           meas_done,
    input  logic [YSZ-1:0]                 meas_top,
    input  logic [YSZ-1:0]                 meas_bottom,
    input  logic [XSZ-1:0]                 meas_right,
    output logic                           busy,
    output logic                           scan_done,
    output logic [$clog2(MAX_STARS+1)-1:0] star_count,
    output logic                           overflow,
    input  logic [$clog2(MAX_STARS)-1:0]   rd_idx,
    output logic [XSZ-1:0]                 rd_x,
    output logic [YSZ-1:0]                 rd_top,
    output logic [YSZ-1:0]                 rd_bottom,
`ifdef STAR_SCAN_TIMEOUT_EN
    output logic                           meas_timeout,
`endif
    output logic [XSZ-1:0]                 rd_right
);

    localparam int unsigned CNT_W = $clog2(MAX_STARS + 1);
    localparam int unsigned IDX_W = $clog2(MAX_STARS);

    state_t             state_q, state_d;
    logic [XSZ-1:0]     x_q, star_x_q, right_q;
    logic [YSZ-1:0]     y_q, star_y_q, top_q, bottom_q;
    logic [ADDR_SZ-1:0] addr_q;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic               do_clear, do_advance, do_launch, do_latch, do_record, do_ovf;
    logic               do_tmo;
    logic               tbl_hit, last_px, candidate;
    star_rec_t          wr_rec, rd_rec;

`ifdef STAR_SCAN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               tmo_q;
    logic               tmo_hit;

    assign tmo_hit = (state_q == StWaitDone) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

    assign last_px   = (x_q == XSZ'(X_RES - 1)) && (y_q == YSZ'(Y_RES - 1));
    assign candidate = (pix_val != COL_SZ'(THRESHOLD)) && !tbl_hit;
    assign wr_rec    = '{x: star_x_q, top: top_q, bottom: bottom_q, right: right_q};

    star_table #(
        .MAX_STARS (MAX_STARS)
    ) u_table (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (do_clear),
        .we      (do_record),
        .wr_idx  (count_q[IDX_W-1:0]),
        .wr_data (wr_rec),
        .q_x     (x_q),
        .q_y     (y_q),
        .hit     (tbl_hit),
        .rd_idx  (rd_idx),
        .rd_data (rd_rec)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath control strobes.
    always_comb begin
        state_d    = state_q;
        do_clear   = 1'b0;
        do_advance = 1'b0;
        do_launch  = 1'b0;
        do_latch   = 1'b0;
        do_record  = 1'b0;
        do_ovf     = 1'b0;
        do_tmo     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    do_clear = 1'b1;
                    state_d  = StFetch;
                end
            end
            StFetch: state_d = StCheck;
            StCheck: begin
                if (candidate) begin
                    do_launch = 1'b1;
                    state_d   = StLaunch;
                end else if (last_px) begin
                    state_d = StDone;
                end else begin
                    do_advance = 1'b1;
                    state_d    = StFetch;
                end
            end
            StLaunch: state_d = StWaitDone;
            StWaitDone: begin
                if (meas_done) begin
                    do_latch = 1'b1;
                    state_d  = StRecord;
                end
`ifdef STAR_SCAN_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Give up on this star and resume at the next pixel.
                    do_tmo = 1'b1;
                    if (last_px) begin
                        state_d = StDone;
                    end else begin
                        do_advance = 1'b1;
                        state_d    = StFetch;
                    end
                end
`endif
            end
            StRecord: begin
                do_record = 1'b1;
                if ((count_q == CNT_W'(MAX_STARS - 1)) && !last_px) begin
                    do_ovf  = 1'b1;
                    state_d = StDone;
                end else if (last_px) begin
                    state_d = StDone;
                end else begin
                    do_advance = 1'b1;
                    state_d    = StFetch;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Scan position, linear ROM address, launch coordinates and results.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q        <= '0;
            y_q        <= '0;
            addr_q     <= '0;
            star_x_q   <= '0;
            star_y_q   <= '0;
            top_q      <= '0;
            bottom_q   <= '0;
            right_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_clear) begin
                x_q        <= '0;
                y_q        <= '0;
                addr_q     <= '0;
                count_q    <= '0;
                overflow_q <= 1'b0;
            end
            if (do_advance) begin
                if (x_q == XSZ'(X_RES - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + YSZ'(1);
                end else begin
                    x_q <= x_q + XSZ'(1);
                end
                addr_q <= addr_q + ADDR_SZ'(1);
            end
            if (do_launch) begin
                star_x_q <= x_q;
                star_y_q <= y_q;
            end
            if (do_latch) begin
                top_q    <= meas_top;
                bottom_q <= meas_bottom;
                right_q  <= meas_right;
            end
            if (do_record) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (do_ovf) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef STAR_SCAN_TIMEOUT_EN
    // Watchdog: counts WAIT_DONE cycles, sticky flag cleared on start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            if (state_q == StWaitDone) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            end else begin
                tmo_cnt_q <= '0;
            end
            if (do_clear) begin
                tmo_q <= 1'b0;
            end else if (do_tmo) begin
                tmo_q <= 1'b1;
            end
        end
    end

    assign meas_timeout = tmo_q;
`endif

    assign pix_addr   = addr_q;
    assign star_found = (state_q == StLaunch);
    assign star_x     = star_x_q;
    assign star_y     = star_y_q;
    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign scan_done  = (state_q == StDone);
    assign star_count = count_q;
    assign overflow   = overflow_q;
    assign rd_x       = rd_rec.x;
    assign rd_top     = rd_rec.top;
    assign rd_bottom  = rd_rec.bottom;
    assign rd_right   = rd_rec.right;

endmodule

// File: tb/tb_star_scan_scheduler.sv
// Scoreboard bench for star_scan_scheduler with a ROM and engine model.
module tb_star_scan_scheduler;

    localparam int XR   = 60;
    localparam int NPIX = 3600;

    typedef struct { int x; int y; } launch_t;
    typedef struct { int top; int bottom; int right; int delay; } resp_t;
    typedef struct { int count; int ovf; int cycles; int addr; } done_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [11:0] pix_addr;
    logic [2:0]  pix_val = 3'd0;
    logic        star_found;
    logic [5:0]  star_x, star_y;
    logic        meas_done = 1'b0;
    logic [5:0]  meas_top = '0, meas_bottom = '0, meas_right = '0;
    logic        busy, scan_done, overflow;
    logic [3:0]  star_count;
    logic [2:0]  rd_idx = '0;
    logic [5:0]  rd_x, rd_top, rd_bottom, rd_right;
`ifdef STAR_SCAN_TIMEOUT_EN
    logic        meas_timeout;
`endif

    star_scan_scheduler #(
        .MAX_STARS   (8)
`ifdef STAR_SCAN_TIMEOUT_EN
        ,
        .TIMEOUT_CYC (16)
`endif
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .pix_addr    (pix_addr),
        .pix_val     (pix_val),
        .star_found  (star_found),
        .star_x      (star_x),
        .star_y      (star_y),
        .meas_done   (meas_done),
        .meas_top    (meas_top),
        .meas_bottom (meas_bottom),
        .meas_right  (meas_right),
        .busy        (busy),
        .scan_done   (scan_done),
        .star_count  (star_count),
        .overflow    (overflow),
        .rd_idx      (rd_idx),
        .rd_x        (rd_x),
        .rd_top      (rd_top),
        .rd_bottom   (rd_bottom),
`ifdef STAR_SCAN_TIMEOUT_EN
        .meas_timeout(meas_timeout),
`endif
        .rd_right    (rd_right)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous image ROM: data valid the cycle after the address.
    bit img [NPIX];
    always @(posedge clk) pix_val <= img[int'(pix_addr)] ? 3'd5 : 3'd0;

    launch_t exp_launch_q[$];
    resp_t   resp_q[$];
    done_t   exp_done_q[$];

    int errors = 0;
    int checks = 0;
    int launches = 0;
    int start_cyc = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: compares launches and scan completions against the scoreboard.
    initial begin
        launch_t l;
        done_t   d;
        forever begin
            @(negedge clk);
            if (resetn && star_found) begin
                launches++;
                if (exp_launch_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_launch: got (%0d,%0d) expected none",
                             star_x, star_y);
                end else begin
                    l = exp_launch_q.pop_front();
                    check("launch_x", int'(star_x), l.x);
                    check("launch_y", int'(star_y), l.y);
                end
            end
            if (resetn && scan_done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scan_done: got count %0d expected none",
                             star_count);
                end else begin
                    d = exp_done_q.pop_front();
                    check("done_count", int'(star_count), d.count);
                    check("done_overflow", int'(overflow), d.ovf);
                    check("done_cycles", cyc - start_cyc, d.cycles);
                    check("done_addr", int'(pix_addr), d.addr);
                    check("done_busy_low", int'(busy), 0);
                end
            end
        end
    end

    // Measurement engine model: answers each launch after resp.delay cycles.
    initial begin
        resp_t r;
        int    cnt = 0;
        forever begin
            @(negedge clk);
            meas_done = 1'b0;
            if (!resetn) begin
                cnt = 0;
            end else if (star_found) begin
                if (resp_q.size() != 0) begin
                    r   = resp_q.pop_front();
                    cnt = r.delay;
                end else begin
                    cnt = 0;
                end
            end else if (cnt != 0) begin
                cnt--;
                if (cnt == 0) begin
                    meas_done   = 1'b1;
                    meas_top    = 6'(r.top);
                    meas_bottom = 6'(r.bottom);
                    meas_right  = 6'(r.right);
                end
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < NPIX; i++) img[i] = 1'b0;
    endtask

    task automatic set_px(input int x, input int y);
        img[y * XR + x] = 1'b1;
    endtask

    task automatic push_star(input int x, input int y, input int top, input int bottom,
                             input int right, input int delay);
        exp_launch_q.push_back('{x, y});
        resp_q.push_back('{top, bottom, right, delay});
    endtask

    task automatic pulse_start();
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
    endtask

    task automatic wait_scan(input int budget);
        int k = 0;
        while (!scan_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!scan_done) begin
            checks++;
            errors++;
            $display("FAIL scan_timeout: got no scan_done expected one within %0d", budget);
        end
        @(negedge clk);
        check("launch_q_drained", exp_launch_q.size(), 0);
        check("done_q_drained", exp_done_q.size(), 0);
    endtask

    task automatic wait_launch(input int budget);
        int k = 0;
        while (!star_found && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!star_found) begin
            checks++;
            errors++;
            $display("FAIL launch_timeout: got no star_found expected one within %0d", budget);
        end
    endtask

    task automatic check_entry(input int idx, input int x, input int top, input int bottom,
                               input int right);
        rd_idx = 3'(idx);
        #1;
        check("rd_x", int'(rd_x), x);
        check("rd_top", int'(rd_top), top);
        check("rd_bottom", int'(rd_bottom), bottom);
        check("rd_right", int'(rd_right), right);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pix_addr"}, int'(pix_addr), 0);
        check({tag, "_star_found"}, int'(star_found), 0);
        check({tag, "_star_x"}, int'(star_x), 0);
        check({tag, "_star_y"}, int'(star_y), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_scan_done"}, int'(scan_done), 0);
        check({tag, "_star_count"}, int'(star_count), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
    endtask

    initial begin
        int l0;
        clear_img();
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        resetn = 1'b1;
        @(negedge clk);

        // Empty image; a second start mid-scan must be ignored.
        l0 = launches;
        exp_done_q.push_back('{0, 0, 7201, 3599});
        pulse_start();
        repeat (100) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_scan(8000);
        check("empty_launches", launches - l0, 0);

        // 4x4 block at x 10..13, y 5..8: one launch, rest excluded.
        clear_img();
        for (int y = 5; y <= 8; y++)
            for (int x = 10; x <= 13; x++) set_px(x, y);
        push_star(10, 5, 5, 8, 13, 3);
        exp_done_q.push_back('{1, 0, 7206, 3599});
        pulse_start();
        wait_scan(8000);
        check_entry(0, 10, 5, 8, 13);

        // Nine isolated pixels: table fills after eight, scan stops early.
        clear_img();
        for (int i = 0; i < 9; i++) set_px(2 * i + 1, 3 * i);
        for (int i = 0; i < 8; i++) push_star(2 * i + 1, 3 * i, 3 * i, 3 * i, 2 * i + 1, 1);
        exp_done_q.push_back('{8, 1, 2577, 1275});
        pulse_start();
        wait_scan(8000);
        check_entry(0, 1, 0, 0, 1);
        check_entry(7, 15, 21, 21, 15);

        // Reset three cycles into WAIT_DONE aborts the scan.
        clear_img();
        set_px(20, 30);
        push_star(20, 30, 30, 30, 20, 100);
        l0 = launches;
        pulse_start();
        wait_launch(8000);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        resetn = 1'b1;
        repeat (300) @(negedge clk);
        check("abort_launches", launches - l0, 1);
        check("abort_launch_q", exp_launch_q.size(), 0);

        // Only the last pixel is bright; scan_done directly after RECORD.
        clear_img();
        set_px(59, 59);
        push_star(59, 59, 59, 59, 59, 4);
        exp_done_q.push_back('{1, 0, 7207, 3599});
        pulse_start();
        wait_scan(8000);
        check_entry(0, 59, 59, 59, 59);

`ifdef STAR_SCAN_TIMEOUT_EN
        // Silent engine: watchdog fires after 16 WAIT_DONE cycles.
        clear_img();
        set_px(10, 5);
        exp_launch_q.push_back('{10, 5});
        exp_done_q.push_back('{0, 0, 7218, 3599});
        pulse_start();
        wait_launch(8000);
        repeat (16) @(negedge clk);
        check("tmo_before", int'(meas_timeout), 0);
        @(negedge clk);
        check("tmo_after", int'(meas_timeout), 1);
        check("tmo_next_addr", int'(pix_addr), 5 * 60 + 11);
        wait_scan(8000);
        check("tmo_sticky", int'(meas_timeout), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/star_scan_scheduler.md
# star_scan_scheduler

Top-level sequencer for the star-finding pipeline. Raster-scans the 60x60 image ROM, detects bright pixels not covered by an already-measured star, and launches the top/bottom measurement engine with the pixel's coordinates. It then waits for that engine's completion pulse, stores the star's bounding data in a small table, and resumes the scan. It owns the ROM address during scanning; the measurement engine owns its own ROM ports.

## Interface
- X_RES, 60, image width in pixels
- Y_RES, 60, image height in pixels
- XSZ, 6, x coordinate width
- YSZ, 6, y coordinate width
- ADDR_SZ, 12, ROM address width
- COL_SZ, 3, pixel value width
- THRESHOLD, 0, background value; a pixel is bright when value != THRESHOLD
- MAX_STARS, 8, star table depth
- TIMEOUT_CYC, 4095, measurement watchdog limit (only with macro)

Ports:
- clk  in  1  clock; one clock domain
- resetn  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a scan when idle
- pix_addr  out  ADDR_SZ  ROM read address
- pix_val  in  COL_SZ  ROM data; valid one cycle after pix_addr is presented
- star_found  out  1  one-cycle launch pulse to the measurement engine
- star_x / star_y  out  XSZ / YSZ  launch coordinates; held stable until meas_done
- meas_done  in  1  one-cycle completion pulse from the engine
- meas_top / meas_bottom  in  YSZ  engine results; sampled in the meas_done cycle
- meas_right  in  XSZ  rightmost bright column; sampled with meas_done
- busy  out  1  high from accepted start until scan_done
- scan_done  out  1  one-cycle pulse at scan end
- star_count  out  $clog2(MAX_STARS+1)  entries recorded
- overflow  out  1  sticky; table filled before the image end
- rd_idx  in  $clog2(MAX_STARS)  table read index
- rd_x, rd_top, rd_bottom, rd_right  out  table entry at rd_idx, combinational

## Operation
- States: IDLE, FETCH, CHECK, LAUNCH, WAIT_DONE, RECORD, DONE.
- IDLE: start=1 loads x=0, y=0, addr=0 and clears star_count and overflow, then goes to FETCH. start in any other state is ignored.
- FETCH: drives pix_addr. The address is a running linear counter incremented by 1 per pixel, so the block has no multiplier. Goes to CHECK.
- CHECK: a pixel is a candidate when it is bright and no valid table entry has x in [entry.x, entry.right] and y in [entry.top, entry.bottom].
  - Candidate: go to LAUNCH.
  - Otherwise, last pixel (x=X_RES-1, y=Y_RES-1): go to DONE.
  - Otherwise: advance x (wrap to 0 with y+1 at X_RES-1) and return to FETCH.
- LAUNCH: star_found=1 for one cycle with star_x/star_y = current x/y, then go to WAIT_DONE.
- WAIT_DONE: hold star_x/star_y. meas_done=1 goes to RECORD with the results latched.
- RECORD: writes {x, top, bottom, right} to entry star_count and increments star_count.
  - If star_count reaches MAX_STARS and this pixel is not the last, set overflow and go to DONE.
  - Else if this is the last pixel, go to DONE.
  - Else advance and go to FETCH.
- DONE: scan_done=1 for one cycle, then IDLE. star_count, overflow and the table hold until the next start.
- meas_done outside WAIT_DONE is ignored.
- rd_* outputs for an index >= star_count are don't-care.

## Timing
- Reset values: pix_addr=0, star_found=0, star_x=0, star_y=0, busy=0, scan_done=0, star_count=0, overflow=0, all table entries invalid, state=IDLE.
- Reset asserted mid-scan or mid-WAIT_DONE aborts immediately. No star_found is reissued after reset.
- Scan cost: 2 cycles per non-candidate pixel. An empty image runs start → scan_done in 2*X_RES*Y_RES+1 cycles (7201).
- Launch overhead per star: LAUNCH + WAIT_DONE (engine-dependent, >=1) + RECORD.
- busy rises the cycle after start is sampled and falls in the scan_done cycle.
- Exclusion compare is combinational in CHECK against the registered table. A star recorded in RECORD is excluded from the next CHECK.

## Configuration
- STAR_SCAN_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE. Reaching TIMEOUT_CYC deasserts the wait, sets a sticky meas_timeout output (reset 0, cleared on start), records nothing, and advances to the next pixel.
- STAR_SCAN_TIMEOUT_EN undefined:
  - WAIT_DONE waits indefinitely.
  - The meas_timeout port is absent.

## Structure
- Package star_pkg holds:
  - state enum
  - X_RES/Y_RES/THRESHOLD defaults
  - star_rec_t struct {x, top, bottom, right}
- Sub-module star_table: MAX_STARS registers with valid bits, write port, rd_idx read port, and parallel exclusion comparators producing a single hit output.

## Test plan
- All-zero image, start → scan_done 7201 cycles later; star_count=0; star_found never asserted; overflow=0.
- Bright block x 10..13, y 5..8. Model returns top=5, bottom=8, right=13 → exactly one star_found with (10,5); star_count=1; rd_idx=0 gives x=10, top=5, bottom=8, right=13.
- Nine isolated single bright pixels, MAX_STARS=8 → 8 launches; overflow=1; scan_done after the 8th RECORD; star_count=8.
- resetn low 3 cycles into WAIT_DONE → all outputs at reset values next cycle; no star_found until a new start.
- Bright pixel only at (59,59), meas_done after 4 cycles → star_count=1; scan_done the cycle after RECORD; no extra FETCH.
- STAR_SCAN_TIMEOUT_EN, TIMEOUT_CYC=16, engine silent → meas_timeout=1 after 16 WAIT_DONE cycles; star_count unchanged; next FETCH at (x+1,y).
